afifo_rd_packer: RTL and testbench

//  Read-side consumer of the async FIFO, on the read clock. Pops BITWID-wide words from the FIFO,

---
 rtl/afifo_pkg.sv | 28 ++
 rtl/afifo_rd_flush_timer.sv | 30 +++
 rtl/afifo_rd_packer.sv | 123 ++++++++++++
 tb/tb_afifo_rd_packer.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/afifo_pkg.sv
// Shared definitions for the async FIFO read-side packer: default sizes and
// small helpers for building the per-word keep mask and locating word lanes.
package afifo_pkg;

    localparam int DEF_BITWID  = 8;
    localparam int DEF_PACK    = 4;
    localparam int DEF_PACKWID = 2;
    localparam int DEF_TIMEOUT = 16;
    localparam int DEF_TOWID   = 5;

    // Mask with the low 'cnt' bits set; callers size-cast it to their lane count.
    function automatic logic [31:0] keep_from_cnt(input int unsigned cnt);
        logic [31:0] mask;
        mask = '0;
        for (int unsigned i = 0; i < 32; i++) begin
            if (i < cnt) begin
                mask[i] = 1'b1;
            end
        end
        return mask;
    endfunction

    // Bit offset of word lane 'idx' inside a packed beat of 'wid'-bit words.
    function automatic int unsigned lane_lo(input int unsigned idx, input int unsigned wid);
        return idx * wid;
    endfunction

endpackage

// File: rtl/afifo_rd_flush_timer.sv
// Idle timer for partial beats: counts cycles in which a partial assembly is
// waiting on an empty FIFO, saturating at TIMEOUT so the flush request holds
// until the packer actually moves the beat out.
module afifo_rd_flush_timer #(
    parameter int TIMEOUT = 16,
    parameter int TOWID   = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic timeout
);

    localparam logic [TOWID-1:0] LIMIT = TOWID'(TIMEOUT);

    logic [TOWID-1:0] idle_cnt;

    // Count idle cycles up to the limit; any progress (word accepted or beat moved) restarts it.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            idle_cnt <= '0;
        end else if (en && (idle_cnt != LIMIT)) begin
            idle_cnt <= idle_cnt + TOWID'(1);
        end
    end

    assign timeout = (idle_cnt == LIMIT);

endmodule

// File: rtl/afifo_rd_packer.sv
// Read-side consumer of the async FIFO: pops words (1-cycle read latency),
// packs PACK of them into one wide beat on a valid/ready stream, and flushes
// partial beats on request or after an idle timeout.
module afifo_rd_packer
    import afifo_pkg::*;
#(
    parameter int BITWID  = DEF_BITWID,
    parameter int PACK    = DEF_PACK,
    parameter int PACKWID = DEF_PACKWID,
    parameter int TIMEOUT = DEF_TIMEOUT,
    parameter int TOWID   = DEF_TOWID
) (
    input  logic                   rd_clk,
    input  logic                   rd_rst,
    input  logic                   fifo_empty,
    output logic                   fifo_rd,
    input  logic [BITWID-1:0]      fifo_rd_dat,
    input  logic                   fifo_rd_dat_valid,
    input  logic                   flush,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [PACK*BITWID-1:0] out_dat,
    output logic [PACK-1:0]        out_keep,
    output logic                   err_unexpected
);

    // One extra bit so the count can reach PACK and eff+inflight never wraps.
    localparam int CNTW = PACKWID + 1;

    logic [BITWID-1:0]      asm_q [PACK];
    logic [CNTW-1:0]        asm_cnt;
    logic [CNTW-1:0]        eff;
    logic                   inflight_q;
    logic                   flush_pend;
    logic                   post_rst_q;
    logic                   timeout;
    logic                   full;
    logic                   have;
    logic                   move;
    logic                   accept;
    logic [PACK-1:0]        keep_mask;
    logic [PACK*BITWID-1:0] beat_dat;

    assign full   = (asm_cnt == CNTW'(PACK));
    assign have   = (asm_cnt != '0);
    assign move   = (full || ((flush_pend || timeout) && have)) && (!out_valid || out_ready);
    assign eff    = move ? '0 : asm_cnt;
    assign accept = fifo_rd_dat_valid && inflight_q;

    // A read is issued only if the word it returns is guaranteed a free slot next cycle.
    assign fifo_rd = !rd_rst && !fifo_empty && ((eff + CNTW'(inflight_q)) < CNTW'(PACK));

    assign keep_mask = PACK'(keep_from_cnt(32'(asm_cnt)));

    // Build the outgoing beat from the filled lanes only; unfilled lanes read as zero.
    always_comb begin
        beat_dat = '0;
        for (int unsigned i = 0; i < PACK; i++) begin
            if (keep_mask[i]) begin
                beat_dat[lane_lo(i, BITWID) +: BITWID] = asm_q[i];
            end
        end
    end

    // Assembly, output register, read tracking, flush request and error flag.
    always_ff @(posedge rd_clk) begin
        if (rd_rst) begin
            for (int i = 0; i < PACK; i++) begin
                asm_q[i] <= '0;
            end
            asm_cnt        <= '0;
            inflight_q     <= 1'b0;
            flush_pend     <= 1'b0;
            post_rst_q     <= 1'b1;
            out_valid      <= 1'b0;
            out_dat        <= '0;
            out_keep       <= '0;
            err_unexpected <= 1'b0;
        end else begin
            post_rst_q <= 1'b0;
            inflight_q <= fifo_rd;

            if (accept) begin
                asm_q[eff[PACKWID-1:0]] <= fifo_rd_dat;
                asm_cnt                 <= eff + CNTW'(1);
            end else if (move) begin
                asm_cnt <= '0;
            end

            if (move) begin
                out_dat   <= beat_dat;
                out_keep  <= keep_mask;
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end

            if (fifo_rd_dat_valid && !inflight_q && !post_rst_q) begin
                err_unexpected <= 1'b1;
            end

            if (move) begin
                flush_pend <= flush;
            end else if (!have && !inflight_q) begin
                flush_pend <= 1'b0;
            end else if (flush) begin
                flush_pend <= 1'b1;
            end
        end
    end

    afifo_rd_flush_timer #(
        .TIMEOUT (TIMEOUT),
        .TOWID   (TOWID)
    ) u_timer (
        .clk     (rd_clk),
        .rst     (rd_rst),
        .clr     (accept || move),
        .en      (have && !inflight_q && fifo_empty),
        .timeout (timeout)
    );

endmodule

// File: tb/tb_afifo_rd_packer.sv
// Scoreboard bench for afifo_rd_packer: a FIFO model feeds words with a
// 1-cycle read latency, a reference model groups each pushed batch into
// expected beats, and a monitor pops and compares accepted beats.
module tb_afifo_rd_packer;

    localparam int BW = 8;
    localparam int PK = 4;

    typedef logic [7:0] byte_q_t[$];
    typedef struct {
        logic [31:0] dat;
        logic [3:0]  keep;
    } beat_t;

    logic          rd_clk = 1'b0;
    logic          rd_rst;
    logic          fifo_empty;
    logic          fifo_rd;
    logic [BW-1:0] fifo_rd_dat;
    logic          fifo_rd_dat_valid;
    logic          flush;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   out_dat;
    logic [3:0]    out_keep;
    logic          err_unexpected;

    int         check_count = 0;
    int         err_count   = 0;
    logic [7:0] fifo_q[$];
    beat_t      exp_q[$];
    int         rd_count    = 0;
    int         beats_seen  = 0;
    bit         inject_req  = 0;
    bit         rand_ready  = 0;
    bit         ready_cmd   = 1;

    afifo_rd_packer dut (
        .rd_clk            (rd_clk),
        .rd_rst            (rd_rst),
        .fifo_empty        (fifo_empty),
        .fifo_rd           (fifo_rd),
        .fifo_rd_dat       (fifo_rd_dat),
        .fifo_rd_dat_valid (fifo_rd_dat_valid),
        .flush             (flush),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .out_dat           (out_dat),
        .out_keep          (out_keep),
        .err_unexpected    (err_unexpected)
    );

    always #5 rd_clk = ~rd_clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        check_count++;
        if (actual !== expected) begin
            err_count++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge rd_clk);
        #1;
    endtask

    // Queue words into the FIFO and record the beats they must form: consecutive groups of PK.
    task automatic applyStimulus(input byte_q_t words);
        beat_t b;
        for (int i = 0; i < words.size(); i++) begin
            fifo_q.push_back(words[i]);
        end
        for (int base = 0; base < words.size(); base += PK) begin
            b.dat  = '0;
            b.keep = '0;
            for (int j = 0; j < PK; j++) begin
                if (base + j < words.size()) begin
                    b.dat[8*j +: 8] = words[base + j];
                    b.keep[j]       = 1'b1;
                end
            end
            exp_q.push_back(b);
        end
    endtask

    task automatic waitDrain(input int budget, input string name);
        int n;
        n = 0;
        while ((fifo_q.size() != 0 || exp_q.size() != 0) && n < budget) begin
            tick();
            n++;
        end
        checkOutput(name, 32'(fifo_q.size() == 0 && exp_q.size() == 0), 32'd1);
    endtask

    // FIFO model: a pop seen before an edge returns its word in the following cycle.
    initial begin
        logic rd_now;
        fifo_rd_dat_valid = 1'b0;
        fifo_rd_dat       = '0;
        fifo_empty        = 1'b1;
        out_ready         = 1'b1;
        forever begin
            @(negedge rd_clk);
            rd_now = fifo_rd;
            if (rd_now) rd_count++;
            @(posedge rd_clk);
            #1;
            if (rd_now) begin
                if (fifo_q.size() == 0) begin
                    checkOutput("rd_while_empty", 32'd1, 32'd0);
                    fifo_rd_dat = 8'h00;
                end else begin
                    fifo_rd_dat = fifo_q.pop_front();
                end
                fifo_rd_dat_valid = 1'b1;
            end else if (inject_req) begin
                fifo_rd_dat       = 8'hEE;
                fifo_rd_dat_valid = 1'b1;
                inject_req        = 0;
            end else begin
                fifo_rd_dat_valid = 1'b0;
            end
            fifo_empty = (fifo_q.size() == 0);
            out_ready  = rand_ready ? ($urandom_range(0, 3) != 0) : ready_cmd;
        end
    end

    // Monitor: checks held beats stay stable and scores every accepted beat.
    initial begin
        bit          prev_hold;
        logic [31:0] prev_dat;
        logic [3:0]  prev_keep;
        beat_t       e;
        prev_hold = 0;
        prev_dat  = '0;
        prev_keep = '0;
        forever begin
            @(negedge rd_clk);
            if (rd_rst !== 1'b0) begin
                prev_hold = 0;
            end else begin
                if (prev_hold) begin
                    checkOutput("hold_valid", 32'(out_valid), 32'd1);
                    checkOutput("hold_dat", out_dat, prev_dat);
                    checkOutput("hold_keep", 32'(out_keep), 32'(prev_keep));
                end
                if (out_valid && out_ready) begin
                    beats_seen++;
                    if (exp_q.size() == 0) begin
                        checkOutput("unexpected_beat", out_dat, 32'hDEADBEEF);
                    end else begin
                        e = exp_q.pop_front();
                        checkOutput("beat_dat", out_dat, e.dat);
                        checkOutput("beat_keep", 32'(out_keep), 32'(e.keep));
                    end
                end
                prev_hold = out_valid && !out_ready;
                prev_dat  = out_dat;
                prev_keep = out_keep;
            end
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        byte_q_t w;
        int      rd_base;
        int      beat_base;
        int      n;

        rd_rst = 1'b1;
        flush  = 1'b0;
        repeat (3) tick();
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_out_dat", out_dat, 32'd0);
        checkOutput("rst_out_keep", 32'(out_keep), 32'd0);
        checkOutput("rst_err", 32'(err_unexpected), 32'd0);

        // Stream of 8 words, loaded while still in reset: no pops until release.
        w = {};
        for (int i = 1; i <= 8; i++) w.push_back(8'(i));
        applyStimulus(w);
        repeat (2) tick();
        checkOutput("rst_fifo_rd", 32'(fifo_rd), 32'd0);
        rd_base   = rd_count;
        beat_base = beats_seen;
        rd_rst    = 1'b0;
        waitDrain(100, "t1_drain");
        checkOutput("t1_reads", 32'(rd_count - rd_base), 32'd8);
        checkOutput("t1_beats", 32'(beats_seen - beat_base), 32'd2);

        // Same stream with the output stalled: assembly fills, reads stop, beat 1 holds.
        ready_cmd = 0;
        beat_base = beats_seen;
        applyStimulus(w);
        repeat (25) tick();
        checkOutput("t2_stall_valid", 32'(out_valid), 32'd1);
        checkOutput("t2_stall_fifo_rd", 32'(fifo_rd), 32'd0);
        checkOutput("t2_stall_dat", out_dat, 32'h04030201);
        checkOutput("t2_all_popped", 32'(fifo_q.size()), 32'd0);
        ready_cmd = 1;
        waitDrain(50, "t2_drain");
        checkOutput("t2_beats", 32'(beats_seen - beat_base), 32'd2);

        // Three words then nothing: partial beat leaves only after the idle timeout.
        w = '{8'hA1, 8'hA2, 8'hA3};
        applyStimulus(w);
        repeat (10) tick();
        checkOutput("t3_no_early_beat", 32'(exp_q.size()), 32'd1);
        waitDrain(40, "t3_timeout_beat");

        // Two words with a flush right after the second pop: beat well before the timeout.
        rd_base = rd_count;
        w = '{8'hB1, 8'hB2};
        applyStimulus(w);
        n = 0;
        while (rd_count < rd_base + 2 && n < 20) begin
            tick();
            n++;
        end
        checkOutput("t4_two_reads", 32'(rd_count - rd_base), 32'd2);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        waitDrain(6, "t4_flush_beat");
        beat_base = beats_seen;
        repeat (3) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        repeat (30) tick();
        checkOutput("t4_empty_flush_valid", 32'(out_valid), 32'd0);
        checkOutput("t4_empty_flush_beats", 32'(beats_seen - beat_base), 32'd0);
        checkOutput("t4_err_clear", 32'(err_unexpected), 32'd0);

        // Unsolicited read data: sticky error, word never packed.
        beat_base  = beats_seen;
        inject_req = 1;
        repeat (3) tick();
        checkOutput("t5_err_set", 32'(err_unexpected), 32'd1);
        repeat (25) tick();
        checkOutput("t5_err_sticky", 32'(err_unexpected), 32'd1);
        checkOutput("t5_no_beat", 32'(beats_seen - beat_base), 32'd0);

        // Random batches against random back-pressure, each batch drained before the next.
        rand_ready = 1;
        for (int r = 0; r < 12; r++) begin
            n = $urandom_range(1, 11);
            w = {};
            for (int i = 0; i < n; i++) w.push_back(8'($urandom));
            applyStimulus(w);
            waitDrain(300, "rand_drain");
            repeat (3) tick();
        end
        rand_ready = 0;
        ready_cmd  = 1;
        repeat (2) tick();

        // Reset with a pending beat and a partial assembly: everything is discarded.
        ready_cmd = 0;
        for (int i = 0; i < 6; i++) fifo_q.push_back(8'(8'hC0 + i));
        repeat (20) tick();
        checkOutput("t6_pre_valid", 32'(out_valid), 32'd1);
        checkOutput("t6_pre_popped", 32'(fifo_q.size()), 32'd0);
        rd_rst = 1'b1;
        tick();
        checkOutput("t6_rst_valid", 32'(out_valid), 32'd0);
        checkOutput("t6_rst_dat", out_dat, 32'd0);
        checkOutput("t6_rst_keep", 32'(out_keep), 32'd0);
        checkOutput("t6_rst_err", 32'(err_unexpected), 32'd0);
        checkOutput("t6_rst_fifo_rd", 32'(fifo_rd), 32'd0);
        rd_rst    = 1'b0;
        ready_cmd = 1;
        repeat (2) tick();
        beat_base = beats_seen;
        w = '{8'hD1, 8'hD2, 8'hD3, 8'hD4};
        applyStimulus(w);
        waitDrain(40, "t6_drain");
        repeat (30) tick();
        checkOutput("t6_one_beat", 32'(beats_seen - beat_base), 32'd1);

        $display("CHECKS %0d ERRORS %0d", check_count, err_count);
        $finish;
    end

endmodule
